// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings and lane helpers for the data-memory access unit
package mem_access_unit_pkg;

  // Request size encodings on req_size
  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Lane masks, right-aligned before shifting into position
  localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_ERR
  } state_t;

  // Bit shift that moves lane 0 onto the addressed lane; halves use addr[1] only,
  // words always sit at lane 0 so forced-aligned accesses ignore the low bits.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] eff;
    case (size)
      SZ_BYTE: eff = off;
      SZ_HALF: eff = {off[1], 1'b0};
      default: eff = 2'b00;
    endcase
    return {eff, 3'b000};
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - byte/half load extract+extend and store lane merge
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_mask;

  // Select the addressed lane, extend it for loads, and splice store data into the read word
  always_comb begin
    w_shift     = lane_shift(i_size, i_off);
    w_lane      = i_rdata >> w_shift;
    w_mask      = LANE_MASK_WORD;
    o_load_data = w_lane;
    case (i_size)
      SZ_BYTE: begin
        w_mask      = LANE_MASK_BYTE;
        o_load_data = {{24{~i_unsigned & w_lane[7]}}, w_lane[7:0]};
      end
      SZ_HALF: begin
        w_mask      = LANE_MASK_HALF;
        o_load_data = {{16{~i_unsigned & w_lane[15]}}, w_lane[15:0]};
      end
      default: ;
    endcase
    o_merge_data = (i_rdata & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store requester for the word-wide data memory
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_req_err;
  logic [31:0]       w_load_data;
  logic [31:0]       w_merge_data;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Classify the incoming request: illegal size always, misalignment only when checking is on
  always_comb begin
    w_req_err = (req_size == SZ_ILLEGAL);
    if (CHECK_ALIGN) begin
      if ((req_size == SZ_HALF) && req_addr[0]) begin
        w_req_err = 1'b1;
      end
      if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
        w_req_err = 1'b1;
      end
    end
  end

  mem_access_unit_lane_align u_lane_align (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_off        (r_off),
    .i_rdata      (mem_rdata),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // Request FSM; every memory-side and response output is a register so enables are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      r_off       <= 2'b00;
      r_wdata     <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The completion pulse lasts one cycle; a new request may be taken in the same cycle
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          if (req_valid) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            if (w_req_err) begin
              r_state <= ST_ERR;
            end else if (!req_we) begin
              r_state   <= ST_LOAD;
              r_mem_ren <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              r_state     <= ST_WRITE;
              r_mem_wen   <= 1'b1;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state   <= ST_RMW_RD;
              r_mem_ren <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_mem_ren   <= 1'b0;
          r_rsp_rdata <= w_load_data;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_RMW_RD: begin
          // Read word and merged write word swap in on one edge so ren and wen never overlap
          r_mem_ren   <= 1'b0;
          r_mem_wen   <= 1'b1;
          r_mem_wdata <= w_merge_data;
          r_state     <= ST_WRITE;
        end
        ST_WRITE: begin
          r_mem_wen   <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        ST_ERR: begin
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_mem_ren <= 1'b0;
          r_mem_wen <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total;
  int bad;

  logic [31:0] mem [0:255];
  int          ren_cnt;
  int          wen_cnt;
  int          overlap_cnt;
  logic [31:0] last_wen_addr;

  mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, word write committed on the falling edge
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(negedge clk) begin
    if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Enable activity monitor
  always @(negedge clk) begin
    if (mem_ren) ren_cnt = ren_cnt + 1;
    if (mem_wen) begin
      wen_cnt = wen_cnt + 1;
      last_wen_addr = mem_addr;
    end
    if (mem_ren && mem_wen) overlap_cnt = overlap_cnt + 1;
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er, output logic ok);
    int guard;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; ok = 1'b0; rd = 32'h0; er = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    total++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin bad++; $display("FAIL rst_en got=%b%b exp=00", mem_ren, mem_wen); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem got=%h/%h exp=0/0", mem_addr, mem_wdata); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er, ok; int w0, r0;
    w0 = wen_cnt; r0 = ren_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er, ok);
    total++; if (!ok || lat !== 2) begin bad++; $display("FAIL wst_lat got=%0d ok=%b exp=2", lat, ok); end
    total++; if (wen_cnt - w0 !== 1 || ren_cnt - r0 !== 0) begin bad++; $display("FAIL wst_en wen=%0d ren=%0d exp=1/0", wen_cnt - w0, ren_cnt - r0); end
    total++; if (last_wen_addr !== 32'h100) begin bad++; $display("FAIL wst_addr got=%h exp=00000100", last_wen_addr); end
    total++; if (mem[8'h40] !== 32'hDEADBEEF) begin bad++; $display("FAIL wst_mem got=%h exp=deadbeef", mem[8'h40]); end
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL wst_rsp got=%h/%b exp=0/0", rd, er); end
    do_req(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, lat, rd, er, ok);
    total++; if (!ok || lat !== 2) begin bad++; $display("FAIL wld_lat got=%0d ok=%b exp=2", lat, ok); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL wld_data got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er, ok; int w0, r0;
    mem[8'h40] = 32'h11223344;
    w0 = wen_cnt; r0 = ren_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h000000AA, lat, rd, er, ok);
    total++; if (!ok || lat !== 3) begin bad++; $display("FAIL bst_lat got=%0d ok=%b exp=3", lat, ok); end
    total++; if (wen_cnt - w0 !== 1 || ren_cnt - r0 !== 1) begin bad++; $display("FAIL bst_en wen=%0d ren=%0d exp=1/1", wen_cnt - w0, ren_cnt - r0); end
    total++; if (mem[8'h40] !== 32'h11AA3344) begin bad++; $display("FAIL bst_mem got=%h exp=11aa3344", mem[8'h40]); end
    do_req(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, lat, rd, er, ok);
    total++; if (!ok || lat !== 2 || rd !== 32'hFFFFFFAA) begin bad++; $display("FAIL bld_s got=%h lat=%0d exp=ffffffaa/2", rd, lat); end
    do_req(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, lat, rd, er, ok);
    total++; if (!ok || rd !== 32'h000000AA) begin bad++; $display("FAIL bld_u got=%h exp=000000aa", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, lat, rd, er, ok);
    total++; if (!ok || rd !== 32'h00000044) begin bad++; $display("FAIL bld_lane0 got=%h exp=00000044", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er, ok;
    mem[8'h41] = 32'h0;
    do_req(1'b1, 2'b01, 1'b0, 32'h106, 32'h00008001, lat, rd, er, ok);
    total++; if (!ok || lat !== 3 || er !== 1'b0) begin bad++; $display("FAIL hst_lat got=%0d err=%b exp=3/0", lat, er); end
    total++; if (mem[8'h41] !== 32'h80010000) begin bad++; $display("FAIL hst_mem got=%h exp=80010000", mem[8'h41]); end
    do_req(1'b0, 2'b01, 1'b0, 32'h106, 32'h0, lat, rd, er, ok);
    total++; if (!ok || rd !== 32'hFFFF8001) begin bad++; $display("FAIL hld_s got=%h exp=ffff8001", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h106, 32'h0, lat, rd, er, ok);
    total++; if (!ok || rd !== 32'h00008001) begin bad++; $display("FAIL hld_u got=%h exp=00008001", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, ok; int w0, r0;
    w0 = wen_cnt; r0 = ren_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, lat, rd, er, ok);
    total++; if (!ok || lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_misal got=%h/%b lat=%0d exp=0/1/2", rd, er, lat); end
    do_req(1'b1, 2'b11, 1'b0, 32'h104, 32'h12345678, lat, rd, er, ok);
    total++; if (!ok || lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_size got=%h/%b lat=%0d exp=0/1/2", rd, er, lat); end
    do_req(1'b1, 2'b01, 1'b0, 32'h103, 32'h1234, lat, rd, er, ok);
    total++; if (!ok || er !== 1'b1) begin bad++; $display("FAIL err_half got=%b exp=1", er); end
    total++; if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 0) begin bad++; $display("FAIL err_en wen=%0d ren=%0d exp=0/0", wen_cnt - w0, ren_cnt - r0); end
    total++; if (mem[8'h41] !== 32'h80010000) begin bad++; $display("FAIL err_mem got=%h exp=80010000", mem[8'h41]); end
  endtask

  task automatic test_back_to_back();
    logic        v_we   [4];
    logic [1:0]  v_sz   [4];
    logic        v_uns  [4];
    logic [31:0] v_addr [4];
    logic [31:0] v_wd   [4];
    logic [31:0] e_rd   [4];
    logic [31:0] g_rd   [4];
    logic        g_er   [4];
    int k, nrsp, no_bubble;
    v_we[0] = 1'b1; v_sz[0] = 2'b10; v_uns[0] = 1'b0; v_addr[0] = 32'h200; v_wd[0] = 32'hCAFEF00D; e_rd[0] = 32'h0;
    v_we[1] = 1'b0; v_sz[1] = 2'b10; v_uns[1] = 1'b0; v_addr[1] = 32'h200; v_wd[1] = 32'h0;        e_rd[1] = 32'hCAFEF00D;
    v_we[2] = 1'b1; v_sz[2] = 2'b00; v_uns[2] = 1'b0; v_addr[2] = 32'h201; v_wd[2] = 32'h0000005A; e_rd[2] = 32'h0;
    v_we[3] = 1'b0; v_sz[3] = 2'b01; v_uns[3] = 1'b1; v_addr[3] = 32'h202; v_wd[3] = 32'h0;        e_rd[3] = 32'h0000CAFE;
    for (int i = 0; i < 4; i++) begin g_rd[i] = 32'hX; g_er[i] = 1'bX; end
    k = 0; nrsp = 0; no_bubble = 1;
    @(negedge clk);
    req_we = v_we[0]; req_size = v_sz[0]; req_unsigned = v_uns[0]; req_addr = v_addr[0]; req_wdata = v_wd[0];
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (rsp_valid) begin
        if (nrsp < 4) begin g_rd[nrsp] = rsp_rdata; g_er[nrsp] = rsp_err; end
        nrsp++;
      end
      if (req_ready && k < 4) begin
        if (k > 0 && !rsp_valid) no_bubble = 0;
        @(posedge clk);
        #1;
        k++;
        if (k < 4) begin
          req_we = v_we[k]; req_size = v_sz[k]; req_unsigned = v_uns[k]; req_addr = v_addr[k]; req_wdata = v_wd[k];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    total++; if (nrsp !== 4 || k !== 4) begin bad++; $display("FAIL b2b_count rsp=%0d acc=%0d exp=4/4", nrsp, k); end
    total++; if (no_bubble !== 1) begin bad++; $display("FAIL b2b_bubble got=%0d exp=1", no_bubble); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (g_rd[i] !== e_rd[i] || g_er[i] !== 1'b0) begin
        bad++; $display("FAIL b2b_rsp%0d got=%h/%b exp=%h/0", i, g_rd[i], g_er[i], e_rd[i]);
      end
    end
    total++; if (mem[8'h80] !== 32'hCAFE5A0D) begin bad++; $display("FAIL b2b_mem got=%h exp=cafe5a0d", mem[8'h80]); end
  endtask

  task automatic test_reset_mid_write();
    int guard, seen_rsp;
    logic wen_before;
    mem[8'hC0] = 32'h12345678;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h300; req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 wen_before = mem_wen;
    total++; if (wen_before !== 1'b1) begin bad++; $display("FAIL rmw_write_state got=%b exp=1", wen_before); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL rst_async_wen got=%b exp=0", mem_wen); end
    seen_rsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    rst_n = 1'b1;
    guard = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
      guard++;
    end
    total++; if (seen_rsp !== 0) begin bad++; $display("FAIL rst_no_rsp got=%0d exp=0", seen_rsp); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (mem[8'hC0] !== 32'h12345678) begin bad++; $display("FAIL rst_mem got=%h exp=12345678", mem[8'hC0]); end
  endtask

  initial begin
    total = 0; bad = 0;
    ren_cnt = 0; wen_cnt = 0; overlap_cnt = 0; last_wen_addr = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL ren_wen_overlap got=%0d exp=0", overlap_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
